// File: rtl/x_delay_measure.sv
// x_delay_measure: counts clocks from a launch rising edge to the next echo rising edge,
// flagging timeouts when no echo is seen and stray echoes that arrive while idle.
module x_delay_measure #(
    parameter int MXDLY = 4,
    parameter int MXCNT = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             launch,
    input  logic             echo,
    output logic             busy,
    output logic             valid,
    output logic [MXDLY-1:0] delay,
    output logic             timeout,
    output logic             stray,
    output logic [MXCNT-1:0] nvalid
);
    localparam int MXSR = 1 << MXDLY;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t           r_state, w_next;
    logic             r_launch_inh, r_echo_inh;
    logic             w_launch_os, w_echo_os, w_last;
    logic [MXDLY-1:0] r_cnt, w_cnt_next, w_delay;
    logic             w_valid, w_timeout, w_stray;
    logic             r_busy, r_valid, r_timeout, r_stray;
    logic [MXDLY-1:0] r_delay;
    logic [MXCNT-1:0] r_nvalid;

    assign w_launch_os = launch & ~r_launch_inh;
    assign w_echo_os   = echo & ~r_echo_inh;
    assign w_last      = r_cnt == MXDLY'(MXSR - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = (w_launch_os && !w_echo_os) ? WAIT : IDLE;
        else                 w_next = (w_echo_os || w_last) ? IDLE : WAIT;
    end

    always_comb begin
        w_valid    = (r_state == IDLE) ? (w_launch_os & w_echo_os) : w_echo_os;
        w_timeout  = (r_state == WAIT) & ~w_echo_os & w_last;
        w_stray    = (r_state == IDLE) & w_echo_os & ~w_launch_os;
        w_delay    = (r_state == IDLE) ? '0 : r_cnt;
        w_cnt_next = (r_state == IDLE) ? MXDLY'(1) : r_cnt + MXDLY'(1);
    end

    // Inhibits start high so an input already asserted at reset release is not an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_launch_inh <= 1'b1;
            r_echo_inh   <= 1'b1;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_stray      <= 1'b0;
            r_delay      <= '0;
            r_nvalid     <= '0;
        end else begin
            r_launch_inh <= launch;
            r_echo_inh   <= echo;
            r_cnt        <= (w_next == WAIT) ? w_cnt_next : '0;
            r_busy       <= w_next == WAIT;
            r_valid      <= w_valid;
            r_timeout    <= w_timeout;
            r_stray      <= w_stray;
            if (w_valid) r_delay <= w_delay;
            if (w_valid && r_nvalid != '1) r_nvalid <= r_nvalid + MXCNT'(1);
        end
    end

    assign busy    = r_busy;
    assign valid   = r_valid;
    assign delay   = r_delay;
    assign timeout = r_timeout;
    assign stray   = r_stray;
    assign nvalid  = r_nvalid;
endmodule
